// File: rtl/ace_snoop_initiator_if.sv
// ACE snoop channel bundle types and the initiator-to-cache snoop interface.
// The package supplies the default AC/CR/CD bundle layout used by the interface.
package ariane_ace;
   typedef struct packed {
      logic [63:0] addr;
      logic [3:0]  snoop;
      logic [2:0]  prot;
   } ac_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } cd_chan_t;

   typedef struct packed {
      logic     ac_valid;
      ac_chan_t ac;
      logic     cr_ready;
      logic     cd_ready;
   } snoop_req_t;

   typedef struct packed {
      logic       ac_ready;
      logic       cr_valid;
      logic [4:0] cr_resp;
      logic       cd_valid;
      cd_chan_t   cd;
   } snoop_resp_t;
endpackage

interface ace_snoop_initiator_if #(
   parameter type snoop_req_t  = ariane_ace::snoop_req_t,
   parameter type snoop_resp_t = ariane_ace::snoop_resp_t
);
   snoop_req_t  snoop_req;
   snoop_resp_t snoop_resp;

   modport master (output snoop_req, input snoop_resp);
   modport slave  (input snoop_req, output snoop_resp);
endinterface

// File: rtl/ace_snoop_initiator.sv
// Single-outstanding ACE snoop initiator: AC out, CR/CD in, response and line upstream.
// Optional CR watchdog with drain path is enabled by defining ACE_SNOOP_TIMEOUT_EN.
module ace_snoop_initiator #(
   parameter int unsigned BeatsPerLine  = 2,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [63:0]           req_addr_i,
   input  logic [3:0]            req_snoop_i,
   input  logic [2:0]            req_prot_i,
   ace_snoop_initiator_if.master snoop_port,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [4:0]            rsp_resp_o,
   output logic                  data_valid_o,
   input  logic                  data_ready_i,
   output logic [63:0]           data_o,
   output logic                  data_last_o,
   output logic                  busy_o
);
   localparam int unsigned OffW = $clog2(BeatsPerLine * 8);
   localparam int unsigned CntW = $clog2(BeatsPerLine) + 1;
   localparam logic [CntW-1:0] LastIdx = CntW'(BeatsPerLine - 1);

   typedef enum logic [2:0] {
      IDLE, SEND_AC, WAIT_CR, DATA, RESP
`ifdef ACE_SNOOP_TIMEOUT_EN
      , DRAIN
`endif
   } state_e;

   state_e          state_q;
   logic [63:0]     addr_q;
   logic [3:0]      snoop_q;
   logic [2:0]      prot_q;
   logic            ac_valid_q, cr_ready_q, rsp_valid_q;
   logic            req_ready_q, busy_q;
   logic [4:0]      rsp_resp_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ac_hs, cr_hs, cd_hs, cd_ready, last_beat;
   logic [4:0]      cr_resp;

   assign cr_resp   = snoop_port.snoop_resp.cr_resp;
   assign ac_hs     = ac_valid_q && snoop_port.snoop_resp.ac_ready;
   assign cr_hs     = cr_ready_q && snoop_port.snoop_resp.cr_valid;
   assign cd_hs     = cd_ready && snoop_port.snoop_resp.cd_valid;
   assign last_beat = (cnt_q == LastIdx);
   assign cnt_d     = cnt_q + 1'b1;

`ifdef ACE_SNOOP_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

   logic [TmoW-1:0] tmo_q;
   logic            timed_out_q, drain_cr_q, drain_dt_q;
   logic [CntW-1:0] drain_cnt_d;
   logic            drain_dt, drain_done;

   // Late CR and its data may arrive in either order while draining.
   assign cd_ready    = (state_q == DATA && data_ready_i) || state_q == DRAIN;
   assign drain_cnt_d = cnt_q + CntW'(cd_hs);
   assign drain_dt    = drain_cr_q ? drain_dt_q : cr_resp[0];
   assign drain_done  = (drain_cr_q || cr_hs) &&
                        (!drain_dt || drain_cnt_d == CntW'(BeatsPerLine));
`else
   assign cd_ready = (state_q == DATA) && data_ready_i;
`endif

   assign snoop_port.snoop_req.ac_valid  = ac_valid_q;
   assign snoop_port.snoop_req.ac.addr   = addr_q;
   assign snoop_port.snoop_req.ac.snoop  = snoop_q;
   assign snoop_port.snoop_req.ac.prot   = prot_q;
   assign snoop_port.snoop_req.cr_ready  = cr_ready_q;
   assign snoop_port.snoop_req.cd_ready  = cd_ready;

   assign req_ready_o  = req_ready_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_resp_o   = rsp_resp_q;
   assign busy_o       = busy_q;
   assign data_valid_o = (state_q == DATA) && snoop_port.snoop_resp.cd_valid;
   assign data_o       = snoop_port.snoop_resp.cd.data;
   assign data_last_o  = (state_q == DATA) && last_beat;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         snoop_q     <= '0;
         prot_q      <= '0;
         ac_valid_q  <= 1'b0;
         cr_ready_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_resp_q  <= '0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
`ifdef ACE_SNOOP_TIMEOUT_EN
         tmo_q       <= '0;
         timed_out_q <= 1'b0;
         drain_cr_q  <= 1'b0;
         drain_dt_q  <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid_i && req_ready_q) begin
                  addr_q      <= {req_addr_i[63:OffW], {OffW{1'b0}}};
                  snoop_q     <= req_snoop_i;
                  prot_q      <= req_prot_i;
                  ac_valid_q  <= 1'b1;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= SEND_AC;
               end
            end
            SEND_AC: begin
               if (ac_hs) begin
                  ac_valid_q <= 1'b0;
                  cr_ready_q <= 1'b1;
                  state_q    <= WAIT_CR;
`ifdef ACE_SNOOP_TIMEOUT_EN
                  tmo_q      <= '0;
`endif
               end
            end
            WAIT_CR: begin
               if (cr_hs) begin
                  cr_ready_q <= 1'b0;
                  rsp_resp_q <= cr_resp;
                  cnt_q      <= '0;
                  if (cr_resp[0]) begin
                     state_q <= DATA;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end
               end
`ifdef ACE_SNOOP_TIMEOUT_EN
               else if (tmo_q == TmoW'(TimeoutCycles - 1)) begin
                  cr_ready_q  <= 1'b0;
                  rsp_resp_q  <= 5'b00010;
                  rsp_valid_q <= 1'b1;
                  timed_out_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            DATA: begin
               if (cd_hs) begin
                  cnt_q <= cnt_d;
                  // Beat count, not cd.last, decides the end of the line.
                  if (snoop_port.snoop_resp.cd.last != last_beat)
                     rsp_resp_q[1] <= 1'b1;
                  if (last_beat) begin
                     rsp_valid_q <= 1'b1;
                     state_q     <= RESP;
                  end
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
`ifdef ACE_SNOOP_TIMEOUT_EN
                  if (timed_out_q) begin
                     timed_out_q <= 1'b0;
                     drain_cr_q  <= 1'b0;
                     drain_dt_q  <= 1'b0;
                     cnt_q       <= '0;
                     cr_ready_q  <= 1'b1;
                     state_q     <= DRAIN;
                  end else begin
                     req_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= IDLE;
                  end
`else
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
`endif
               end
            end
`ifdef ACE_SNOOP_TIMEOUT_EN
            DRAIN: begin
               cnt_q <= drain_cnt_d;
               if (cr_hs) begin
                  drain_cr_q <= 1'b1;
                  drain_dt_q <= cr_resp[0];
                  cr_ready_q <= 1'b0;
               end
               if (drain_done) begin
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   a_cfg: assert property (@(posedge clk_i)
      (BeatsPerLine inside {2, 4, 8, 16}) && (TimeoutCycles > 0));

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// Directed bench for ace_snoop_initiator: vector table plus hand-written corner sequences.
// The timeout/drain sequence is compiled in when ACE_SNOOP_TIMEOUT_EN is defined.
module tb_ace_snoop_initiator;
   localparam int N = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_ready;
   logic [63:0] req_addr;
   logic [3:0]  req_snoop;
   logic [2:0]  req_prot;
   logic        rsp_valid, rsp_ready;
   logic [4:0]  rsp_resp;
   logic        data_valid, data_ready, data_last;
   logic [63:0] data;
   logic        busy;
   int          checks = 0;
   int          errors = 0;

   ace_snoop_initiator_if sif ();

   ace_snoop_initiator #(.BeatsPerLine(N), .TimeoutCycles(16)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_addr_i   (req_addr),
      .req_snoop_i  (req_snoop),
      .req_prot_i   (req_prot),
      .snoop_port   (sif),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_resp_o   (rsp_resp),
      .data_valid_o (data_valid),
      .data_ready_i (data_ready),
      .data_o       (data),
      .data_last_o  (data_last),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  snoop;
      logic [63:0] addr;
      logic [2:0]  prot;
      int          ac_wait;
      logic [4:0]  cr;
      logic [63:0] d0;
      logic [63:0] d1;
      logic        last0;
      logic        last1;
      logic [63:0] exp_addr;
      logic [4:0]  exp_resp;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req_valid  = 1'b0;
      req_addr   = '0;
      req_snoop  = '0;
      req_prot   = '0;
      rsp_ready  = 1'b0;
      data_ready = 1'b0;
      sif.snoop_resp = '0;
   endtask

   task automatic issue(input logic [3:0] sn, input logic [63:0] ad, input logic [2:0] pr);
      chk("issue_req_ready", req_ready, 1);
      req_valid = 1'b1;
      req_addr  = ad;
      req_snoop = sn;
      req_prot  = pr;
      step();
      req_valid = 1'b0;
      req_addr  = '0;
   endtask

   task automatic run_vec(input vec_t v, input int i);
      issue(v.snoop, v.addr, v.prot);
      sif.snoop_resp.ac_ready = 1'b0;
      for (int k = 0; k < v.ac_wait; k++) begin
         chk($sformatf("v%0d_ac_valid_hold", i), sif.snoop_req.ac_valid, 1);
         chk($sformatf("v%0d_ac_addr_hold", i), sif.snoop_req.ac.addr, v.exp_addr);
         chk($sformatf("v%0d_ac_snoop_hold", i), sif.snoop_req.ac.snoop, v.snoop);
         chk($sformatf("v%0d_ac_prot_hold", i), sif.snoop_req.ac.prot, v.prot);
         chk($sformatf("v%0d_req_ready_busy", i), req_ready, 0);
         step();
      end
      sif.snoop_resp.ac_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_ac_valid", i), sif.snoop_req.ac_valid, 1);
      chk($sformatf("v%0d_ac_addr", i), sif.snoop_req.ac.addr, v.exp_addr);
      chk($sformatf("v%0d_busy", i), busy, 1);
      step();
      sif.snoop_resp.ac_ready = 1'b0;
      chk($sformatf("v%0d_ac_drop", i), sif.snoop_req.ac_valid, 0);
      chk($sformatf("v%0d_cr_ready", i), sif.snoop_req.cr_ready, 1);
      sif.snoop_resp.cr_valid = 1'b1;
      sif.snoop_resp.cr_resp  = v.cr;
      step();
      sif.snoop_resp.cr_valid = 1'b0;
      if (v.cr[0]) begin
         data_ready = 1'b1;
         sif.snoop_resp.cd_valid = 1'b1;
         sif.snoop_resp.cd.data  = v.d0;
         sif.snoop_resp.cd.last  = v.last0;
         #1;
         chk($sformatf("v%0d_dvalid0", i), data_valid, 1);
         chk($sformatf("v%0d_data0", i), data, v.d0);
         chk($sformatf("v%0d_dlast0", i), data_last, 0);
         chk($sformatf("v%0d_rsp_early", i), rsp_valid, 0);
         step();
         sif.snoop_resp.cd.data = v.d1;
         sif.snoop_resp.cd.last = v.last1;
         #1;
         chk($sformatf("v%0d_data1", i), data, v.d1);
         chk($sformatf("v%0d_dlast1", i), data_last, 1);
         step();
         sif.snoop_resp.cd_valid = 1'b0;
         data_ready = 1'b0;
      end
      chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_rsp_resp", i), rsp_resp, v.exp_resp);
      chk($sformatf("v%0d_no_data", i), data_valid, 0);
      step();
      chk($sformatf("v%0d_rsp_held", i), rsp_valid, 1);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_done", i), rsp_valid, 0);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      chk($sformatf("v%0d_idle_ready", i), req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{4'b0001, 64'h0000_0000_8000_1040, 3'b010, 0, 5'b01001,
                  64'hAAAA_0000_1111_2222, 64'hBBBB_3333_4444_5555, 1'b0, 1'b1,
                  64'h0000_0000_8000_1040, 5'b01001};
      vecs[1] = '{4'b1101, 64'h0000_0000_4000_2000, 3'b001, 5, 5'b10000,
                  64'h0, 64'h0, 1'b0, 1'b0,
                  64'h0000_0000_4000_2000, 5'b10000};
      vecs[2] = '{4'b0111, 64'h1234_5678_9ABC_DEF7, 3'b111, 1, 5'b00101,
                  64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1,
                  64'h1234_5678_9ABC_DEF0, 5'b00101};
      vecs[3] = '{4'b1001, 64'h0000_0000_0000_0080, 3'b000, 0, 5'b00001,
                  64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b1, 1'b1,
                  64'h0000_0000_0000_0080, 5'b00011};
      vecs[4] = '{4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 2, 5'b00000,
                  64'h0, 64'h0, 1'b0, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFF0, 5'b00000};
      vecs[5] = '{4'b0001, 64'h0000_0000_0000_1238, 3'b010, 0, 5'b01001,
                  64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1'b0,
                  64'h0000_0000_0000_1230, 5'b01011};

      idle_inputs();
      #12;
      chk("rst_ac_valid", sif.snoop_req.ac_valid, 0);
      chk("rst_cr_ready", sif.snoop_req.cr_ready, 0);
      chk("rst_cd_ready", sif.snoop_req.cd_ready, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_resp", rsp_resp, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready_low", req_ready, 0);
      step();
      chk("post_rst_ready_high", req_ready, 1);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // CD beat offered before CR, upstream ready toggling
      sif.snoop_resp.cd_valid = 1'b1;
      sif.snoop_resp.cd.data  = 64'hCAFE_0000_0000_000A;
      sif.snoop_resp.cd.last  = 1'b0;
      data_ready = 1'b1;
      issue(4'b0001, 64'h0000_0000_8000_1040, 3'b000);
      chk("early_cd_ready_ac", sif.snoop_req.cd_ready, 0);
      chk("early_dvalid_ac", data_valid, 0);
      sif.snoop_resp.ac_ready = 1'b1;
      step();
      sif.snoop_resp.ac_ready = 1'b0;
      chk("early_cd_ready_cr1", sif.snoop_req.cd_ready, 0);
      step();
      chk("early_cd_ready_cr2", sif.snoop_req.cd_ready, 0);
      sif.snoop_resp.cr_valid = 1'b1;
      sif.snoop_resp.cr_resp  = 5'b01001;
      #1;
      chk("early_cd_ready_crhs", sif.snoop_req.cd_ready, 0);
      step();
      sif.snoop_resp.cr_valid = 1'b0;
      data_ready = 1'b0;
      #1;
      chk("early_dvalid_a", data_valid, 1);
      chk("early_stall_a", sif.snoop_req.cd_ready, 0);
      step();
      data_ready = 1'b1;
      #1;
      chk("early_ready_a", sif.snoop_req.cd_ready, 1);
      chk("early_data_a", data, 64'hCAFE_0000_0000_000A);
      chk("early_last_a", data_last, 0);
      step();
      sif.snoop_resp.cd.data = 64'hCAFE_0000_0000_000B;
      sif.snoop_resp.cd.last = 1'b1;
      data_ready = 1'b0;
      #1;
      chk("early_stall_b", sif.snoop_req.cd_ready, 0);
      chk("early_data_b", data, 64'hCAFE_0000_0000_000B);
      chk("early_last_b", data_last, 1);
      chk("early_no_rsp", rsp_valid, 0);
      step();
      data_ready = 1'b1;
      #1;
      chk("early_ready_b", sif.snoop_req.cd_ready, 1);
      step();
      sif.snoop_resp.cd_valid = 1'b0;
      data_ready = 1'b0;
      chk("early_rsp_valid", rsp_valid, 1);
      chk("early_rsp_resp", rsp_resp, 5'b01001);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("early_idle", busy, 0);

      // Asynchronous reset in the middle of a line
      issue(4'b0111, 64'h0000_0000_9000_0000, 3'b000);
      sif.snoop_resp.ac_ready = 1'b1;
      step();
      sif.snoop_resp.ac_ready = 1'b0;
      sif.snoop_resp.cr_valid = 1'b1;
      sif.snoop_resp.cr_resp  = 5'b00001;
      step();
      sif.snoop_resp.cr_valid = 1'b0;
      sif.snoop_resp.cd_valid = 1'b1;
      sif.snoop_resp.cd.data  = 64'h1;
      data_ready = 1'b1;
      step();
      sif.snoop_resp.cd.data = 64'h2;
      sif.snoop_resp.cd.last = 1'b1;
      #1;
      chk("mid_dvalid", data_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dvalid", data_valid, 0);
      chk("mid_rst_cd_ready", sif.snoop_req.cd_ready, 0);
      chk("mid_rst_req_ready", req_ready, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_rsp_resp", rsp_resp, 0);
      chk("mid_rst_ac_valid", sif.snoop_req.ac_valid, 0);
      chk("mid_rst_cr_ready", sif.snoop_req.cr_ready, 0);
      idle_inputs();
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("mid_rst_recover", req_ready, 1);
      chk("mid_rst_idle_busy", busy, 0);

`ifdef ACE_SNOOP_TIMEOUT_EN
      issue(4'b0001, 64'h0000_0000_7000_0040, 3'b000);
      sif.snoop_resp.ac_ready = 1'b1;
      step();
      sif.snoop_resp.ac_ready = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         chk($sformatf("tmo_wait%0d", k), rsp_valid, 0);
         step();
      end
      chk("tmo_rsp_valid", rsp_valid, 1);
      chk("tmo_rsp_resp", rsp_resp, 5'b00010);
      chk("tmo_busy", busy, 1);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("drain_cr_ready", sif.snoop_req.cr_ready, 1);
      chk("drain_req_ready0", req_ready, 0);
      sif.snoop_resp.cr_valid = 1'b1;
      sif.snoop_resp.cr_resp  = 5'b01001;
      step();
      sif.snoop_resp.cr_valid = 1'b0;
      sif.snoop_resp.cd_valid = 1'b1;
      sif.snoop_resp.cd.data  = 64'hD0;
      sif.snoop_resp.cd.last  = 1'b0;
      #1;
      chk("drain_cd_ready", sif.snoop_req.cd_ready, 1);
      chk("drain_dvalid", data_valid, 0);
      step();
      chk("drain_req_ready1", req_ready, 0);
      sif.snoop_resp.cd.data = 64'hD1;
      sif.snoop_resp.cd.last = 1'b1;
      step();
      sif.snoop_resp.cd_valid = 1'b0;
      chk("drain_req_ready2", req_ready, 1);
      chk("drain_busy", busy, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
